regfile_dump_unit: RTL and testbench

- Hardware counterpart of the bench-side register printout: on request, walks the pipelined processor's register file through a spare combinational read port.
- Emits one (index, value, stamp) record per register on a valid/ready stream, in the fixed display order $s0-$s7, $t0-$t7, $t8, $t9 (regs 16-23, 8-15, 24, 25).
- Sits beside the register file; consumer is a debug UART or trace buffer.

---
 rtl/pipeline_dbg_pkg.sv | 30 +++
 rtl/reg_order_rom.sv | 21 ++
 rtl/regfile_dump_unit.sv | 102 ++++++++++
 tb/tb_regfile_dump_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_dbg_pkg.sv
// Shared constants, dump ordering and FSM encoding for the register-file dump unit.
// REGFILE_DUMP_ALL_EN selects a full 0..31 dump instead of the 18-entry display order.
package pipeline_dbg_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int SW_DEF = 32;
  localparam int PTR_W  = 5;

`ifdef REGFILE_DUMP_ALL_EN
  localparam int N_DUMP = 32;
`else
  localparam int N_DUMP = 18;
`endif

  // $s0-$s7, $t0-$t7, $t8, $t9
  localparam logic [4:0] DISPLAY_ORDER [0:17] = '{
    5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
    5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
    5'd24, 5'd25
  };

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2,
    ST_DONE    = 2'd3
  } dump_state_e;

endpackage

// File: rtl/reg_order_rom.sv
// Maps a dump pointer to the register index to read.
// REGFILE_DUMP_ALL_EN makes the mapping the identity over 0..31.
module reg_order_rom
  import pipeline_dbg_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic [PTR_W-1:0] i_ptr,
  output logic [AW-1:0]    o_idx
);

`ifdef REGFILE_DUMP_ALL_EN
  assign o_idx = AW'(i_ptr);
`else
  always_comb begin
    o_idx = '0;
    if (i_ptr < PTR_W'(N_DUMP)) o_idx = AW'(DISPLAY_ORDER[i_ptr]);
  end
`endif

endmodule

// File: rtl/regfile_dump_unit.sv
// Walks the register file through a spare read port and streams (idx, value, stamp)
// records on a valid/ready interface. REGFILE_DUMP_ALL_EN selects a full 32-entry dump.
module regfile_dump_unit
  import pipeline_dbg_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dump_req,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] out_stamp,
  output logic          out_last,
  output logic          busy,
  output logic          dump_done
);

  dump_state_e      r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [SW-1:0]    r_cnt;
  logic [AW-1:0]    w_idx;
  logic             w_bypass;
  logic [DW-1:0]    w_cap_data;

  reg_order_rom #(.AW(AW)) u_rom (
    .i_ptr (r_ptr),
    .o_idx (w_idx)
  );

  // The read port is only meaningful while capturing; park it at 0 otherwise.
  assign rf_raddr = (r_state == ST_CAPTURE) ? w_idx : '0;

  // A WB write landing in the capture cycle has not reached the array yet.
  assign w_bypass = wb_we && (wb_waddr == w_idx) && (wb_waddr != '0);

  always_comb begin
    w_cap_data = rf_rdata;
    if (w_idx == '0)   w_cap_data = '0;
    else if (w_bypass) w_cap_data = wb_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_stamp <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      r_cnt     <= r_cnt + 1'b1;
      dump_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (dump_req) begin
            r_state   <= ST_CAPTURE;
            r_ptr     <= '0;
            out_stamp <= r_cnt;
            busy      <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          out_idx   <= w_idx;
          out_data  <= w_cap_data;
          out_last  <= (r_ptr == PTR_W'(N_DUMP - 1));
          out_valid <= 1'b1;
          r_state   <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              r_state   <= ST_DONE;
              busy      <= 1'b0;
              dump_done <= 1'b1;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= ST_CAPTURE;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: ordering, stamp, stall, bypass, busy-ignore, reset abort.
// Honours REGFILE_DUMP_ALL_EN for the expected order and record count.
module tb_regfile_dump_unit;

`ifdef REGFILE_DUMP_ALL_EN
  localparam int N   = 32;
  localparam int BP1 = 0;
`else
  localparam int N   = 18;
  localparam int BP1 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dump_req = 1'b0;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic [31:0] out_data;
  logic [31:0] out_stamp;
  logic        out_last;
  logic        busy;
  logic        dump_done;

  logic [31:0] rf [32];
  logic [31:0] tb_cnt;
  int n_err = 0;
  int n_checks = 0;
  int done_cnt;
  logic [31:0] stamp2;

  always #5 clk = ~clk;

  assign rf_rdata = rf[rf_raddr];

  always @(posedge clk) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 1;
  end

  regfile_dump_unit dut (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .out_stamp(out_stamp), .out_last(out_last),
    .busy(busy), .dump_done(dump_done)
  );

  function automatic logic [4:0] exp_order(input int k);
`ifdef REGFILE_DUMP_ALL_EN
    if (k >= 0 && k < 32) return 5'(k);
    return 5'd0;
`else
    if (k >= 0 && k < 8)  return 5'(16 + k);
    if (k >= 8 && k < 16) return 5'(k);
    if (k == 16) return 5'd24;
    if (k == 17) return 5'd25;
    return 5'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives the stream from the first SEND onward; returns early on abort_rec.
  task automatic collect(input int stall_rec, input int abort_rec, input int bp_rec,
                         input bit req_again, input logic [31:0] exp_stamp);
    int rec, cyc, stall, post, first_cyc;
    logic [4:0]  idx_e;
    logic [31:0] data_e;
    rec = 0; cyc = 0; stall = 0; post = 0; first_cyc = -1; done_cnt = 0;
    out_ready = 1'b1;
    while (cyc < 400 && post < 4) begin
      @(negedge clk);
      cyc++;
      dump_req = 1'b0;
      wb_we    = 1'b0;
      if (done_cnt > 0) post++;
      if (dump_done) done_cnt++;
      if (busy && !out_valid && rec == bp_rec) begin
        wb_we    = 1'b1;
        wb_waddr = exp_order(rec);
        wb_wdata = 32'hDEADBEEF;
      end
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        idx_e  = exp_order(rec);
        data_e = (rec == bp_rec && idx_e != 5'd0) ? 32'hDEADBEEF : rf[idx_e];
        if (rec == abort_rec) begin
          rst_n = 1'b0;
          return;
        end
        if (rec == stall_rec && stall < 10) begin
          out_ready = 1'b0;
          stall++;
          chk("stall_idx", 64'(out_idx), 64'(idx_e));
          chk("stall_data", 64'(out_data), 64'(data_e));
        end else begin
          out_ready = 1'b1;
          chk("rec_idx", 64'(out_idx), 64'(idx_e));
          chk("rec_data", 64'(out_data), 64'(data_e));
          chk("rec_stamp", 64'(out_stamp), 64'(exp_stamp));
          chk("rec_last", 64'(out_last), 64'(rec == N - 1));
          if (rec == 0 && req_again) dump_req = 1'b1;
          rec++;
        end
      end
    end
    chk("first_latency", 64'(first_cyc), 64'd1);
    chk("n_records", 64'(rec), 64'(N));
    chk("done_pulses", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0]  = 32'h0;
    rf[16] = 32'h11;
    rf[8]  = 32'h80;
    rf[25] = 32'h25;
    rf[17] = 32'h1717;

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(dump_done), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_stamp", 64'(out_stamp), 64'd0);
    chk("rst_raddr", 64'(rf_raddr), 64'd0);

    // Dump 1: request when the counter reads 5; stall, bypass and re-request inside
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    chk("cap_valid", 64'(out_valid), 64'd0);
    chk("cap_busy", 64'(busy), 64'd1);
    chk("cap_raddr", 64'(rf_raddr), 64'(exp_order(0)));
    collect(2, -1, BP1, 1'b1, 32'd5);
    chk("end_busy", 64'(busy), 64'd0);
    chk("end_valid", 64'(out_valid), 64'd0);

    // Dump 2: reset during record 5's SEND
    stamp2 = tb_cnt;
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    collect(-1, 4, -1, 1'b0, stamp2);
    @(negedge clk);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(dump_done), 64'd0);
    chk("abort_stamp", 64'(out_stamp), 64'd0);

    // Dump 3: immediately after reset, the stamp shows the counter restarted at 0
    rst_n = 1'b1;
    dump_req = 1'b1;
    @(negedge clk);
    dump_req = 1'b0;
    chk("restart_busy", 64'(busy), 64'd1);
    chk("restart_raddr", 64'(rf_raddr), 64'(exp_order(0)));
    collect(-1, -1, -1, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
